// File: rtl/gf180mcu_pwrsw_seq.sv
// gf180mcu_pwrsw_seq: thermometer power-switch segment sequencer.
// Ramps NSEG switch enables up/down, STEP cycles apart, PGOOD after SETTLE.
module gf180mcu_pwrsw_seq #(
  parameter int NSEG   = 8,
  parameter int STEP   = 4,
  parameter int SETTLE = 8
) (
  input  logic            CLK,
  input  logic            RN,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            EN,
  output logic [NSEG-1:0] SW_EN,
  output logic            PGOOD,
  output logic            BUSY
);

  typedef enum logic [2:0] {
    S_OFF,
    S_UP,
    S_SETTLE,
    S_ON,
    S_DOWN
  } state_t;

  localparam logic [7:0] STEP_LD   = 8'(STEP - 1);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
  localparam logic [NSEG-1:0] SEG_ONE = NSEG'(1);

  state_t          state;
  logic [7:0]      cnt;
  logic [NSEG-1:0] sw_up;
  logic [NSEG-1:0] sw_dn;
  logic            last_up;
  logic            last_dn;
  logic            cnt_zero;
  logic            unused_pins;

  // Thermometer code: one step up/down is a shift.
  assign sw_up    = {SW_EN[NSEG-2:0], 1'b1};
  assign sw_dn    = {1'b0, SW_EN[NSEG-1:1]};
  assign last_up  = SW_EN[NSEG-2];
  assign last_dn  = !SW_EN[1];
  assign cnt_zero = (cnt == 8'd0);

  assign unused_pins = VDD ^ VSS;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= S_OFF;
      SW_EN <= '0;
      PGOOD <= 1'b0;
      BUSY  <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_OFF: begin
          if (EN) begin
            SW_EN <= sw_up;
            cnt   <= STEP_LD;
            state <= S_UP;
            BUSY  <= 1'b1;
          end
        end

        S_UP: begin
          if (!EN) begin
            SW_EN <= sw_dn;
            if (last_dn) begin
              cnt   <= '0;
              state <= S_OFF;
              BUSY  <= 1'b0;
            end else begin
              cnt   <= STEP_LD;
              state <= S_DOWN;
            end
          end else if (cnt_zero) begin
            SW_EN <= sw_up;
            if (last_up) begin
              cnt   <= SETTLE_LD;
              state <= S_SETTLE;
            end else begin
              cnt   <= STEP_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_SETTLE: begin
          if (!EN) begin
            SW_EN <= sw_dn;
            cnt   <= STEP_LD;
            state <= S_DOWN;
          end else if (cnt_zero) begin
            PGOOD <= 1'b1;
            state <= S_ON;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_ON: begin
          if (!EN) begin
            PGOOD <= 1'b0;
            SW_EN <= sw_dn;
            cnt   <= STEP_LD;
            state <= S_DOWN;
            BUSY  <= 1'b1;
          end
        end

        S_DOWN: begin
          if (EN) begin
            // Reverse direction immediately: re-enable the next segment.
            SW_EN <= sw_up;
            if (last_up) begin
              cnt   <= SETTLE_LD;
              state <= S_SETTLE;
            end else begin
              cnt   <= STEP_LD;
              state <= S_UP;
            end
          end else if (cnt_zero) begin
            SW_EN <= sw_dn;
            if (last_dn) begin
              cnt   <= '0;
              state <= S_OFF;
              BUSY  <= 1'b0;
            end else begin
              cnt   <= STEP_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        default: begin
          state <= S_OFF;
          SW_EN <= '0;
          PGOOD <= 1'b0;
          BUSY  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  a_therm: assert property (
    @(posedge CLK) disable iff (!RN)
    (SW_EN & (SW_EN + SEG_ONE)) == '0
  );

  a_pgood: assert property (
    @(posedge CLK) disable iff (!RN)
    PGOOD |-> ((&SW_EN) && (state == S_ON))
  );

  a_busy: assert property (
    @(posedge CLK) disable iff (!RN)
    BUSY == (state inside {S_UP, S_SETTLE, S_DOWN})
  );

endmodule
